// File: rtl/datapath_seq.sv
// Multi-cycle register-file datapath: a command is captured in IDLE and then
// walks RDA -> RDB -> EXE -> WB, reading operands, executing and writing back.
module datapath_seq #(
  parameter int W    = 16,
  parameter int NREG = 8,
  parameter int IMMW = 8,
  localparam int AW  = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [AW-1:0]   cmd_rn,
  input  logic [AW-1:0]   cmd_rm,
  input  logic [AW-1:0]   cmd_rd,
  input  logic [1:0]      cmd_aluop,
  input  logic [1:0]      cmd_shift,
  input  logic            cmd_asel,
  input  logic            cmd_bsel,
  input  logic [IMMW-1:0] cmd_imm,
  input  logic [1:0]      cmd_wbsel,
  input  logic            cmd_we,
  input  logic            cmd_ls,
  input  logic [W-1:0]    mdata,
  input  logic [W-1:0]    pc,
  output logic [W-1:0]    result,
  output logic            n_out,
  output logic            v_out,
  output logic            z_out,
  output logic            done,
  input  logic [AW-1:0]   dbg_addr,
  output logic [W-1:0]    dbg_data
);

  typedef enum logic [2:0] {IDLE, RDA, RDB, EXE, WB} state_t;

  state_t state;

  logic [W-1:0]    regs [NREG];
  logic [W-1:0]    a_reg, b_reg, c_reg;

  logic [AW-1:0]   rn_q, rm_q, rd_q;
  logic [1:0]      aluop_q, shift_q, wbsel_q;
  logic            asel_q, bsel_q, we_q, ls_q;
  logic [IMMW-1:0] imm_q;
  logic [W-1:0]    mdata_q, pc_q;

  logic [W-1:0]    sximm, a_in, b_sh, b_in, alu_r, wb_val;
  logic            alu_v;

  always_comb begin
    sximm = W'($signed(imm_q));
    a_in  = asel_q ? '0 : a_reg;
    case (shift_q)
      2'b01:   b_sh = {b_reg[W-2:0], 1'b0};
      2'b10:   b_sh = {1'b0, b_reg[W-1:1]};
      2'b11:   b_sh = {b_reg[W-1], b_reg[W-1:1]};
      default: b_sh = b_reg;
    endcase
    b_in  = bsel_q ? sximm : b_sh;

    alu_r = '0;
    alu_v = 1'b0;
    case (aluop_q)
      2'b00: begin
        alu_r = a_in + b_in;
        alu_v = (a_in[W-1] == b_in[W-1]) && (alu_r[W-1] != a_in[W-1]);
      end
      2'b01: begin
        alu_r = a_in - b_in;
        alu_v = (a_in[W-1] != b_in[W-1]) && (alu_r[W-1] != a_in[W-1]);
      end
      2'b10:   alu_r = a_in & b_in;
      default: alu_r = ~b_in;
    endcase

    case (wbsel_q)
      2'b01:   wb_val = sximm;
      2'b10:   wb_val = mdata_q;
      2'b11:   wb_val = pc_q;
      default: wb_val = c_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cmd_ready <= 1'b1;
      done      <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      c_reg     <= '0;
      n_out     <= 1'b0;
      v_out     <= 1'b0;
      z_out     <= 1'b0;
      for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
      rn_q      <= '0;
      rm_q      <= '0;
      rd_q      <= '0;
      aluop_q   <= '0;
      shift_q   <= '0;
      wbsel_q   <= '0;
      asel_q    <= 1'b0;
      bsel_q    <= 1'b0;
      we_q      <= 1'b0;
      ls_q      <= 1'b0;
      imm_q     <= '0;
      mdata_q   <= '0;
      pc_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            rn_q      <= cmd_rn;
            rm_q      <= cmd_rm;
            rd_q      <= cmd_rd;
            aluop_q   <= cmd_aluop;
            shift_q   <= cmd_shift;
            wbsel_q   <= cmd_wbsel;
            asel_q    <= cmd_asel;
            bsel_q    <= cmd_bsel;
            we_q      <= cmd_we;
            ls_q      <= cmd_ls;
            imm_q     <= cmd_imm;
            mdata_q   <= mdata;
            pc_q      <= pc;
            cmd_ready <= 1'b0;
            state     <= RDA;
          end
        end
        RDA: begin
          a_reg <= regs[rn_q];
          state <= RDB;
        end
        RDB: begin
          b_reg <= regs[rm_q];
          state <= EXE;
        end
        EXE: begin
          c_reg <= alu_r;
          if (ls_q) begin
            n_out <= alu_r[W-1];
            v_out <= alu_v;
            z_out <= (alu_r == '0);
          end
          done  <= 1'b1;
          state <= WB;
        end
        WB: begin
          if (we_q) regs[rd_q] <= wb_val;
          done      <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          done      <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

  assign result   = c_reg;
  assign dbg_data = regs[dbg_addr];

endmodule

// File: tb/tb_datapath_seq.sv
// Directed bench for datapath_seq: hand-computed vectors per feature, checked
// on the falling edge, away from the active clock edge.
module tb_datapath_seq;
  localparam int W = 16, NREG = 8, IMMW = 8, AW = 3;

  logic            clk = 1'b0;
  logic            reset, cmd_valid, cmd_ready;
  logic [AW-1:0]   cmd_rn, cmd_rm, cmd_rd, dbg_addr;
  logic [1:0]      cmd_aluop, cmd_shift, cmd_wbsel;
  logic            cmd_asel, cmd_bsel, cmd_we, cmd_ls;
  logic [IMMW-1:0] cmd_imm;
  logic [W-1:0]    mdata, pc, result, dbg_data;
  logic            n_out, v_out, z_out, done;

  int vectors = 0, miscompares = 0;

  always #5 clk = ~clk;

  datapath_seq #(.W(W), .NREG(NREG), .IMMW(IMMW)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_rn(cmd_rn), .cmd_rm(cmd_rm), .cmd_rd(cmd_rd), .cmd_aluop(cmd_aluop),
    .cmd_shift(cmd_shift), .cmd_asel(cmd_asel), .cmd_bsel(cmd_bsel),
    .cmd_imm(cmd_imm), .cmd_wbsel(cmd_wbsel), .cmd_we(cmd_we), .cmd_ls(cmd_ls),
    .mdata(mdata), .pc(pc), .result(result), .n_out(n_out), .v_out(v_out),
    .z_out(z_out), .done(done), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic read_reg(input int idx, output logic [W-1:0] v);
    dbg_addr = AW'(idx);
    #1;
    v = dbg_data;
  endtask

  task automatic set_fields(input logic [AW-1:0] rn, rm, rd, input logic [1:0] aluop, shift,
                            input logic asel, bsel, input logic [IMMW-1:0] imm,
                            input logic [1:0] wbsel, input logic we, ls,
                            input logic [W-1:0] md, pcv);
    cmd_rn = rn; cmd_rm = rm; cmd_rd = rd; cmd_aluop = aluop; cmd_shift = shift;
    cmd_asel = asel; cmd_bsel = bsel; cmd_imm = imm; cmd_wbsel = wbsel;
    cmd_we = we; cmd_ls = ls; mdata = md; pc = pcv;
  endtask

  // Starts and ends on a falling edge; lat counts edges from accept to done.
  task automatic run_cmd(input logic [AW-1:0] rn, rm, rd, input logic [1:0] aluop, shift,
                         input logic asel, bsel, input logic [IMMW-1:0] imm,
                         input logic [1:0] wbsel, input logic we, ls,
                         input logic [W-1:0] md, pcv, output int lat);
    set_fields(rn, rm, rd, aluop, shift, asel, bsel, imm, wbsel, we, ls, md, pcv);
    cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    set_fields(~rn, ~rm, ~rd, ~aluop, ~shift, ~asel, ~bsel, ~imm, ~wbsel, ~we, ~ls, ~md, ~pcv);
    lat = 1;
    while (done !== 1'b1 && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [W-1:0] v;
    reset = 1'b1; cmd_valid = 1'b0; dbg_addr = '0;
    set_fields('0, '0, '0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", done); end
    vectors++; if (result !== 16'h0000) begin miscompares++; $display("FAIL reset_result: got %h expected 0000", result); end
    vectors++; if ({n_out, v_out, z_out} !== 3'b000) begin miscompares++; $display("FAIL reset_flags: got %b expected 000", {n_out, v_out, z_out}); end
    read_reg(1, v);
    vectors++; if (v !== 16'h0000) begin miscompares++; $display("FAIL reset_r1: got %h expected 0000", v); end
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b expected 1", cmd_ready); end
  endtask

  task automatic test_imm_load();
    int lat;
    logic [W-1:0] v;
    run_cmd(3'd0, 3'd0, 3'd1, 2'b00, 2'b00, 1'b0, 1'b0, 8'h05, 2'b01, 1'b1, 1'b0, '0, '0, lat);
    vectors++; if (lat !== 4) begin miscompares++; $display("FAIL imm1_latency: got %0d expected 4", lat); end
    read_reg(1, v);
    vectors++; if (v !== 16'h0005) begin miscompares++; $display("FAIL imm1_r1: got %h expected 0005", v); end
    run_cmd(3'd0, 3'd0, 3'd2, 2'b00, 2'b00, 1'b0, 1'b0, 8'hFD, 2'b01, 1'b1, 1'b0, '0, '0, lat);
    vectors++; if (lat !== 4) begin miscompares++; $display("FAIL imm2_latency: got %0d expected 4", lat); end
    read_reg(2, v);
    vectors++; if (v !== 16'hFFFD) begin miscompares++; $display("FAIL imm2_r2: got %h expected FFFD", v); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL done_pulse_width: got %b expected 0", done); end
  endtask

  task automatic test_add();
    int lat;
    logic [W-1:0] v;
    run_cmd(3'd1, 3'd2, 3'd3, 2'b00, 2'b00, 1'b0, 1'b0, 8'h00, 2'b00, 1'b1, 1'b1, '0, '0, lat);
    vectors++; if (result !== 16'h0002) begin miscompares++; $display("FAIL add_result: got %h expected 0002", result); end
    read_reg(3, v);
    vectors++; if (v !== 16'h0002) begin miscompares++; $display("FAIL add_r3: got %h expected 0002", v); end
    vectors++; if ({n_out, v_out, z_out} !== 3'b000) begin miscompares++; $display("FAIL add_flags: got %b expected 000", {n_out, v_out, z_out}); end
  endtask

  task automatic test_overflow();
    int lat;
    logic [W-1:0] v;
    run_cmd(3'd0, 3'd0, 3'd4, 2'b00, 2'b00, 1'b0, 1'b0, 8'h7F, 2'b01, 1'b1, 1'b0, '0, '0, lat);
    read_reg(4, v);
    vectors++; if (v !== 16'h007F) begin miscompares++; $display("FAIL imm7f_r4: got %h expected 007F", v); end
    run_cmd(3'd0, 3'd0, 3'd4, 2'b00, 2'b00, 1'b0, 1'b0, 8'h01, 2'b01, 1'b1, 1'b0, '0, '0, lat);
    for (int i = 0; i < 14; i++)
      run_cmd(3'd0, 3'd4, 3'd4, 2'b00, 2'b01, 1'b1, 1'b0, 8'h00, 2'b00, 1'b1, 1'b0, '0, '0, lat);
    read_reg(4, v);
    vectors++; if (v !== 16'h4000) begin miscompares++; $display("FAIL lsl_chain_r4: got %h expected 4000", v); end
    run_cmd(3'd4, 3'd4, 3'd5, 2'b00, 2'b00, 1'b0, 1'b0, 8'h00, 2'b00, 1'b1, 1'b1, '0, '0, lat);
    vectors++; if (result !== 16'h8000) begin miscompares++; $display("FAIL ovf_result: got %h expected 8000", result); end
    vectors++; if ({n_out, v_out, z_out} !== 3'b110) begin miscompares++; $display("FAIL ovf_flags: got %b expected 110", {n_out, v_out, z_out}); end
  endtask

  task automatic test_sub_zero();
    int lat;
    logic [W-1:0] v;
    run_cmd(3'd1, 3'd1, 3'd3, 2'b01, 2'b00, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 1'b1, '0, '0, lat);
    vectors++; if (result !== 16'h0000) begin miscompares++; $display("FAIL sub_result: got %h expected 0000", result); end
    vectors++; if ({n_out, v_out, z_out} !== 3'b001) begin miscompares++; $display("FAIL sub_flags: got %b expected 001", {n_out, v_out, z_out}); end
    read_reg(3, v);
    vectors++; if (v !== 16'h0002) begin miscompares++; $display("FAIL sub_no_write_r3: got %h expected 0002", v); end
    read_reg(1, v);
    vectors++; if (v !== 16'h0005) begin miscompares++; $display("FAIL sub_no_write_r1: got %h expected 0005", v); end
  endtask

  task automatic test_wb_sources();
    int lat;
    logic [W-1:0] v;
    run_cmd(3'd0, 3'd0, 3'd6, 2'b00, 2'b00, 1'b0, 1'b0, 8'h00, 2'b10, 1'b1, 1'b0, 16'h8001, 16'hAAAA, lat);
    read_reg(6, v);
    vectors++; if (v !== 16'h8001) begin miscompares++; $display("FAIL wb_mdata_r6: got %h expected 8001", v); end
    run_cmd(3'd0, 3'd0, 3'd7, 2'b00, 2'b00, 1'b0, 1'b0, 8'h00, 2'b11, 1'b1, 1'b0, 16'h5555, 16'h1234, lat);
    read_reg(7, v);
    vectors++; if (v !== 16'h1234) begin miscompares++; $display("FAIL wb_pc_r7: got %h expected 1234", v); end
  endtask

  task automatic test_shift();
    int lat;
    logic [W-1:0] exp_r [4] = '{16'h8001, 16'h0002, 16'h4000, 16'hC000};
    logic         exp_n [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int s = 0; s < 4; s++) begin
      run_cmd(3'd0, 3'd6, 3'd0, 2'b00, 2'(s), 1'b1, 1'b0, 8'h00, 2'b00, 1'b0, 1'b1, '0, '0, lat);
      vectors++; if (result !== exp_r[s]) begin miscompares++; $display("FAIL shift%0d_result: got %h expected %h", s, result, exp_r[s]); end
      vectors++; if ({n_out, v_out, z_out} !== {exp_n[s], 2'b00}) begin miscompares++; $display("FAIL shift%0d_flags: got %b expected %b00", s, {n_out, v_out, z_out}, exp_n[s]); end
    end
  endtask

  task automatic test_alu_ops();
    int lat;
    run_cmd(3'd1, 3'd2, 3'd0, 2'b10, 2'b00, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 1'b1, '0, '0, lat);
    vectors++; if (result !== 16'h0005 || {n_out, v_out, z_out} !== 3'b000) begin miscompares++; $display("FAIL and_op: got %h/%b expected 0005/000", result, {n_out, v_out, z_out}); end
    run_cmd(3'd0, 3'd0, 3'd0, 2'b11, 2'b00, 1'b0, 1'b1, 8'h0F, 2'b00, 1'b0, 1'b1, '0, '0, lat);
    vectors++; if (result !== 16'hFFF0 || {n_out, v_out, z_out} !== 3'b100) begin miscompares++; $display("FAIL notb_op: got %h/%b expected FFF0/100", result, {n_out, v_out, z_out}); end
    run_cmd(3'd5, 3'd0, 3'd0, 2'b01, 2'b00, 1'b0, 1'b1, 8'h01, 2'b00, 1'b0, 1'b1, '0, '0, lat);
    vectors++; if (result !== 16'h7FFF || {n_out, v_out, z_out} !== 3'b010) begin miscompares++; $display("FAIL sub_ovf: got %h/%b expected 7FFF/010", result, {n_out, v_out, z_out}); end
    run_cmd(3'd1, 3'd0, 3'd0, 2'b00, 2'b00, 1'b0, 1'b1, 8'h00, 2'b00, 1'b0, 1'b0, '0, '0, lat);
    vectors++; if (result !== 16'h0005 || {n_out, v_out, z_out} !== 3'b010) begin miscompares++; $display("FAIL ls0_hold: got %h/%b expected 0005/010", result, {n_out, v_out, z_out}); end
    run_cmd(3'd1, 3'd0, 3'd0, 2'b00, 2'b00, 1'b0, 1'b1, 8'hFB, 2'b00, 1'b0, 1'b1, '0, '0, lat);
    vectors++; if (result !== 16'h0000 || {n_out, v_out, z_out} !== 3'b001) begin miscompares++; $display("FAIL add_negimm: got %h/%b expected 0000/001", result, {n_out, v_out, z_out}); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] v;
    set_fields(3'd7, 3'd0, 3'd7, 2'b00, 2'b00, 1'b0, 1'b1, 8'h01, 2'b00, 1'b1, 1'b0, '0, '0);
    cmd_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      vectors++; if (cmd_ready !== (i % 5 == 0)) begin miscompares++; $display("FAIL b2b_ready_c%0d: got %b expected %b", i, cmd_ready, (i % 5 == 0)); end
      vectors++; if (done !== (i % 5 == 4)) begin miscompares++; $display("FAIL b2b_done_c%0d: got %b expected %b", i, done, (i % 5 == 4)); end
      @(posedge clk);
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    read_reg(7, v);
    vectors++; if (v !== 16'h1236) begin miscompares++; $display("FAIL b2b_r7: got %h expected 1236", v); end
  endtask

  task automatic test_reset_abort();
    logic [W-1:0] v;
    bit seen_done;
    set_fields(3'd0, 3'd0, 3'd3, 2'b00, 2'b00, 1'b0, 1'b0, 8'h55, 2'b01, 1'b1, 1'b0, '0, '0);
    cmd_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    cmd_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    set_fields(3'd0, 3'd0, 3'd2, 2'b00, 2'b00, 1'b0, 1'b0, 8'h77, 2'b01, 1'b1, 1'b0, '0, '0);
    cmd_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    cmd_valid = 1'b0;
    vectors++; if (cmd_ready !== 1'b1 || done !== 1'b0) begin miscompares++; $display("FAIL abort_state: got ready=%b done=%b expected 1/0", cmd_ready, done); end
    vectors++; if (result !== 16'h0000 || {n_out, v_out, z_out} !== 3'b000) begin miscompares++; $display("FAIL abort_clear: got %h/%b expected 0000/000", result, {n_out, v_out, z_out}); end
    for (int r = 0; r < NREG; r++) begin
      read_reg(r, v);
      vectors++; if (v !== 16'h0000) begin miscompares++; $display("FAIL abort_r%0d: got %h expected 0000", r, v); end
    end
    @(posedge clk); @(negedge clk);
    vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL abort_ready_after: got %b expected 1", cmd_ready); end
    seen_done = 1'b0;
    repeat (6) begin
      if (done === 1'b1) seen_done = 1'b1;
      @(posedge clk); @(negedge clk);
    end
    vectors++; if (seen_done !== 1'b0) begin miscompares++; $display("FAIL abort_no_queue: got done seen=%b expected 0", seen_done); end
    read_reg(2, v);
    vectors++; if (v !== 16'h0000) begin miscompares++; $display("FAIL abort_r2_after: got %h expected 0000", v); end
  endtask

  initial begin
    reset = 1'b1;
    cmd_valid = 1'b0;
    dbg_addr = '0;
    @(negedge clk);
    test_reset();
    test_imm_load();
    test_add();
    test_overflow();
    test_sub_zero();
    test_wb_sources();
    test_shift();
    test_alu_ops();
    test_back_to_back();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
